mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter that shares one memory port among four requesters, e.g. IF, MEM, a DMA engine and a debug port. It grants one requester at a time, drives the 2-bit select of the shared-port 4:1 muxes, holds the grant until the memory acknowledges, and returns read data plus a completion pulse to the winner. A watchdog ends any transaction the memory never acknowledges.

## Interface
Parameters:
- `data_width`, 32, width of write and read data.
- `addr_width`, 32, width of the address.
- `timeout`, 255, number of BUSY cycles without `mem_ready` before abort. 0 disables the watchdog. Counter width is 8 bits, so the legal range is 0–255.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-requester request; bit i belongs to requester i.
- `req_we`  in  4  per-requester write enable.
- `req_addr`  in  4*addr_width  packed addresses; requester i occupies slice [i*addr_width +: addr_width].
- `req_wdata`  in  4*data_width  packed write data, same slicing.
- `done`  out  4  one-cycle completion pulse to the granted requester.
- `err`  out  4  one-cycle timeout pulse; always coincides with `done`.
- `resp_rdata`  out  data_width  read data latched at completion.
- `sel`  out  2  index of the current grant; drives the mux `control` inputs.
- `mem_valid`  out  1  memory access in progress.
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/addr_width/data_width  payload of the selected requester.
- `mem_rdata`  in  data_width  memory read data.
- `mem_ready`  in  1  memory acknowledge, one cycle.

## Operation
- FSM has two states.
  - IDLE: if `req` != 0, pick the winner, latch `sel` and go to BUSY.
  - BUSY: wait for `mem_ready` or timeout, then return to IDLE.
- Priority order is round-robin: `last+1`, `last+2`, `last+3`, `last` (mod 4, wrapping 3→0). `last` updates to the winner on every completion, including a timeout.
- `mem_valid` = (state == BUSY).
- `mem_we`, `mem_addr` and `mem_wdata` are combinational muxes of the requester payloads indexed by the registered `sel`.
- Requesters hold `req` and their payload stable until they see `done`.
- A requester dropping `req` while granted has no effect; the transaction still completes.
- Requests from non-granted requesters are ignored while BUSY.
- Normal completion: `mem_ready` high in BUSY. On that edge, `done[sel]` <= 1, `resp_rdata` <= `mem_rdata` (reads and writes alike), state <= IDLE.
- Timeout completion: watchdog counter clears on entry to BUSY and increments each BUSY cycle. When it reaches `timeout` with `mem_ready` low, `done[sel]` and `err[sel]` <= 1, `resp_rdata` <= 0, state <= IDLE.
- `mem_ready` in the same cycle as the timeout: this is a normal completion, with no `err`.
- `mem_ready` while IDLE is ignored.
- Reset values:
  - state IDLE, `last` = 3 (requester 0 wins first).
  - `sel` = 0, `done` = 0, `err` = 0, `resp_rdata` = 0, counter = 0.
  - `mem_valid` = 0.
- Reset asserted mid-transaction aborts it immediately with no `done` pulse. After release the arbiter re-arbitrates from requester 0.

## Timing
- Request high at edge N in IDLE: at N+1, state is BUSY, `mem_valid` = 1 and `sel` = winner.
- `mem_ready` sampled high at edge M: `done` is high for the cycle after M, and state is IDLE in that cycle.
- Minimum occupancy is 2 cycles per transaction (BUSY + IDLE), i.e. 1 cycle of memory latency.
- Next grant: earliest BUSY is 2 cycles after the previous BUSY ended.
- A requester that keeps `req` high through its `done` cycle is re-arbitrated in that IDLE cycle.
- Timeout with `timeout` = T: `err` pulses T+1 cycles after BUSY entry.
- All outputs are registered except the memory payload muxes.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` (IDLE, BUSY)
  - `NUM_REQ` = 4
  - `SEL_W` = 2
  - `WDOG_W` = 8
- Sub-module `rr_pick4`: combinational 4-way round-robin picker.
  - Inputs: `req[3:0]`, `last[1:0]`.
  - Outputs: `any`, `win[1:0]`.
- Payload muxing reuses the existing `mux_4_to_1` three times (`addr`, `wdata`, and `we` with data_width 1), all controlled by `sel`.

## Test plan
- **Reset:** hold `reset_n` = 0 with `req` = 4'b1111 → all outputs 0 and `sel` = 0. After release, the first grant goes to requester 0; `mem_valid` rises one cycle later.
- **Fairness:** `req` = 4'b1111 held, memory acks after 3 cycles → grant order 0,1,2,3,0. Each `done` is single-cycle and `resp_rdata` matches `mem_rdata` = 32'hA5A5_0000 + i.
- **Wrap and skip:** `last` = 2, `req` = 4'b0011 → grant 0, then 1, then 0.
- **Timeout:** `timeout` = 4, `mem_ready` never asserted → `done[g]` and `err[g]` pulse 5 cycles after BUSY entry, and `resp_rdata` = 0. With `mem_ready` asserted on the 4th BUSY cycle → `done` only, no `err`.
- **Mid-operation behaviour:**
  - Granted requester drops `req` → transaction still completes with a `done` pulse.
  - `reset_n` pulsed low in BUSY → no `done`; `mem_valid` goes to 0 asynchronously.
- **Payload routing:** requester 2 writes address 32'h100 with data 32'hDEAD_BEEF → `sel` = 2, `mem_we` = 1, `mem_addr` = 32'h100 and `mem_wdata` = 32'hDEAD_BEEF for the whole BUSY window.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int WDOG_W  = 8;

endpackage

// File: rtl/mux_4_to_1.sv
// rtl/mux_4_to_1.sv - generic 4:1 multiplexer
//
// Ports:
//   in_0..in_3  data_width  candidate inputs
//   control     2           index of the input routed to out
//   out         data_width  selected input
module mux_4_to_1 #(
    parameter int data_width = 32
) (
    input  logic [data_width-1:0] in_0,
    input  logic [data_width-1:0] in_1,
    input  logic [data_width-1:0] in_2,
    input  logic [data_width-1:0] in_3,
    input  logic [1:0]            control,
    output logic [data_width-1:0] out
);

    always_comb begin
        out = in_0;
        case (control)
            2'd0:    out = in_0;
            2'd1:    out = in_1;
            2'd2:    out = in_2;
            2'd3:    out = in_3;
            default: out = in_0;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin picker
//
// Ports:
//   req   4  request vector, bit i belongs to requester i
//   last  2  most recently served requester (lowest priority this round)
//   any   1  at least one request is pending
//   win   2  chosen requester; only meaningful when any is high
module rr_pick4
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   win
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // Scan last+1, last+2, last+3 and finally last itself. The 2-bit
    // addition wraps 3->0 for free, and k == 4 lands back on last.
    always_comb begin
        any   = |req;
        win   = last;
        found = 1'b0;
        idx   = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + SEL_W'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port among four requesters
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req, req_we           per-requester request and write enable
//   req_addr, req_wdata   packed per-requester payloads, requester i at [i*W +: W]
//   done, err             one-cycle completion / timeout pulses to the granted requester
//   resp_rdata            read data captured at completion (0 on timeout)
//   sel                   registered grant index, drives the payload mux controls
//   mem_valid             access in progress
//   mem_we/addr/wdata     payload of the granted requester (combinational mux)
//   mem_rdata, mem_ready  memory read data and one-cycle acknowledge
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int data_width = 32,
    parameter int addr_width = 32,
    parameter int timeout    = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*addr_width-1:0] req_addr,
    input  logic [NUM_REQ*data_width-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic [data_width-1:0]         resp_rdata,
    output logic [SEL_W-1:0]              sel,
    output logic                          mem_valid,
    output logic                          mem_we,
    output logic [addr_width-1:0]         mem_addr,
    output logic [data_width-1:0]         mem_wdata,
    input  logic [data_width-1:0]         mem_rdata,
    input  logic                          mem_ready
);

    // A timeout of 0 turns the watchdog off entirely.
    localparam bit                WDOG_EN  = (timeout != 0);
    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(timeout);

    arb_state_t                state_q;
    logic [SEL_W-1:0]          last_q;
    logic [SEL_W-1:0]          sel_q;
    logic [NUM_REQ-1:0]        done_q;
    logic [NUM_REQ-1:0]        err_q;
    logic [data_width-1:0]     rdata_q;
    logic [WDOG_W-1:0]         cnt_q;
    logic                      valid_q;

    logic                      pick_any;
    logic [SEL_W-1:0]          pick_win;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .win  (pick_win)
    );

    // Arbitration FSM. done/err default low every cycle so they can only
    // ever be one-cycle pulses. last_q moves to the served requester on
    // every completion, timeouts included, so a hung requester cannot
    // monopolise the port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= SEL_W'(NUM_REQ - 1);
            sel_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        sel_q   <= pick_win;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // mem_ready wins over a simultaneous watchdog expiry.
                    if (mem_ready) begin
                        done_q[sel_q] <= 1'b1;
                        rdata_q       <= mem_rdata;
                        last_q        <= sel_q;
                        valid_q       <= 1'b0;
                        state_q       <= IDLE;
                    end else if (WDOG_EN && (cnt_q == WDOG_LIM)) begin
                        done_q[sel_q] <= 1'b1;
                        err_q[sel_q]  <= 1'b1;
                        rdata_q       <= '0;
                        last_q        <= sel_q;
                        valid_q       <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + WDOG_W'(1);
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Shared-port payload, steered by the registered grant.
    mux_4_to_1 #(.data_width(addr_width)) u_mux_addr (
        .in_0    (req_addr[0*addr_width +: addr_width]),
        .in_1    (req_addr[1*addr_width +: addr_width]),
        .in_2    (req_addr[2*addr_width +: addr_width]),
        .in_3    (req_addr[3*addr_width +: addr_width]),
        .control (sel_q),
        .out     (mem_addr)
    );

    mux_4_to_1 #(.data_width(data_width)) u_mux_wdata (
        .in_0    (req_wdata[0*data_width +: data_width]),
        .in_1    (req_wdata[1*data_width +: data_width]),
        .in_2    (req_wdata[2*data_width +: data_width]),
        .in_3    (req_wdata[3*data_width +: data_width]),
        .control (sel_q),
        .out     (mem_wdata)
    );

    mux_4_to_1 #(.data_width(1)) u_mux_we (
        .in_0    (req_we[0]),
        .in_1    (req_we[1]),
        .in_2    (req_we[2]),
        .in_3    (req_we[3]),
        .control (sel_q),
        .out     (mem_we)
    );

    assign done       = done_q;
    assign err        = err_q;
    assign resp_rdata = rdata_q;
    assign sel        = sel_q;
    assign mem_valid  = valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [3:0]  done;
        logic [3:0]  err;
        logic [31:0] rdata;
    } cpl_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = 4'b0;
    logic [3:0]   req_we = 4'b0;
    logic [127:0] req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [3:0]   done;
    logic [3:0]   err;
    logic [31:0]  resp_rdata;
    logic [1:0]   sel;
    logic         mem_valid;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata = '0;
    logic         mem_ready = 1'b0;

    int   checks = 0;
    int   errors = 0;
    cpl_t exp_q[$];
    cpl_t exp_e;
    cpl_t obs_e;

    mem_port_arbiter #(
        .data_width (32),
        .addr_width (32),
        .timeout    (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .done       (done),
        .err        (err),
        .resp_rdata (resp_rdata),
        .sel        (sel),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    // Scoreboard: every completion the DUT reports is popped against the
    // expectation pushed when the acknowledging stimulus was driven.
    always @(negedge clk) begin
        if (reset_n && (done != 4'b0 || err != 4'b0)) begin
            obs_e = '{done: done, err: err, rdata: resp_rdata};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got done=%b err=%b rdata=%h, required no completion",
                         done, err, resp_rdata);
            end else begin
                exp_e = exp_q.pop_front();
                if (obs_e !== exp_e) begin
                    errors++;
                    $display("FAIL sb_completion: got done=%b err=%b rdata=%h, required done=%b err=%b rdata=%h",
                             obs_e.done, obs_e.err, obs_e.rdata, exp_e.done, exp_e.err, exp_e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Called in BUSY cycle 1; raises mem_ready in BUSY cycle lat and
    // returns in the following (done) cycle with mem_ready low again.
    task automatic ack_after(input int lat, input logic [31:0] rd, input int idx);
        cpl_t e;
        for (int c = 1; c < lat; c++) tick();
        e.done  = 4'b0001 << idx;
        e.err   = 4'b0;
        e.rdata = rd;
        exp_q.push_back(e);
        mem_ready = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b1111;
        tick(); tick(); tick();
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL rst_done: got %b, required 0000", done); end
        checks++; if (err !== 4'b0) begin errors++; $display("FAIL rst_err: got %b, required 0000", err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h, required 0", resp_rdata); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d, required 0", sel); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", mem_valid); end
        reset_n = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %b, required 0", mem_valid); end
        tick();
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rst_first_valid: got %b, required 1", mem_valid); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_first_sel: got %0d, required 0", sel); end
    endtask

    // Entered in BUSY cycle 1 of the grant to requester 0 made after reset.
    task automatic test_fairness();
        for (int i = 0; i < 5; i++) begin
            checks++; if (sel !== 2'(i % 4)) begin errors++; $display("FAIL fair_sel[%0d]: got %0d, required %0d", i, sel, i % 4); end
            checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL fair_valid[%0d]: got %b, required 1", i, mem_valid); end
            ack_after(3, 32'hA5A5_0000 + 32'(i), i % 4);
            checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL fair_idle[%0d]: got %b, required 0", i, mem_valid); end
            if (i == 4) req = 4'b0;
            tick();
        end
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL fair_single_done: got %b, required 0000", done); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL fair_end_valid: got %b, required 0", mem_valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fair_pending: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_payload();
        cpl_t e;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32]  = 32'h1000 * 32'(i) + 32'h10;
            req_wdata[i*32 +: 32] = 32'h1111_1111 * 32'(i);
        end
        req_addr[2*32 +: 32]  = 32'h100;
        req_wdata[2*32 +: 32] = 32'hDEAD_BEEF;
        req_we = 4'b0100;
        req    = 4'b0100;
        tick();
        for (int c = 1; c <= 3; c++) begin
            checks++; if (sel !== 2'd2) begin errors++; $display("FAIL pay_sel[%0d]: got %0d, required 2", c, sel); end
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL pay_we[%0d]: got %b, required 1", c, mem_we); end
            checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL pay_addr[%0d]: got %h, required 00000100", c, mem_addr); end
            checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pay_wdata[%0d]: got %h, required deadbeef", c, mem_wdata); end
            if (c == 3) begin
                e = '{done: 4'b0100, err: 4'b0, rdata: 32'h0BAD_F00D};
                exp_q.push_back(e);
                mem_ready = 1'b1;
                mem_rdata = 32'h0BAD_F00D;
            end
            tick();
        end
        mem_ready = 1'b0;
        req       = 4'b0;
        req_we    = 4'b0;
        tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL pay_pending: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    // Follows test_payload, so the last served requester is 2.
    task automatic test_wrap_skip();
        req = 4'b0011;
        tick();
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL wrap_sel0: got %0d, required 0", sel); end
        ack_after(1, 32'h0000_0A00, 0);
        tick();
        checks++; if (sel !== 2'd1) begin errors++; $display("FAIL wrap_sel1: got %0d, required 1", sel); end
        ack_after(1, 32'h0000_0A01, 1);
        tick();
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL wrap_sel2: got %0d, required 0", sel); end
        ack_after(2, 32'h0000_0A02, 0);
        req = 4'b0;
        tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        cpl_t e;
        req       = 4'b0010;
        mem_rdata = 32'h1234_5678;
        tick();
        e = '{done: 4'b0010, err: 4'b0010, rdata: 32'h0};
        exp_q.push_back(e);
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++; if (done !== 4'b0 || mem_valid !== 1'b1) begin errors++; $display("FAIL to_early[%0d]: got done=%b valid=%b, required done=0000 valid=1", c, done, mem_valid); end
        end
        tick();
        checks++; if (done !== 4'b0010) begin errors++; $display("FAIL to_done: got %b, required 0010", done); end
        checks++; if (err !== 4'b0010) begin errors++; $display("FAIL to_err: got %b, required 0010", err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h, required 0", resp_rdata); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL to_valid: got %b, required 0", mem_valid); end
        req = 4'b0;
        tick();
        req = 4'b0010;
        tick();
        ack_after(4, 32'hCAFE_0004, 1);
        checks++; if (done !== 4'b0010 || err !== 4'b0) begin errors++; $display("FAIL to_ack4: got done=%b err=%b, required done=0010 err=0000", done, err); end
        // req held through done: re-granted straight away, then acked
        // in the very cycle the watchdog expires.
        tick();
        checks++; if (mem_valid !== 1'b1 || sel !== 2'd1) begin errors++; $display("FAIL to_regrant: got valid=%b sel=%0d, required valid=1 sel=1", mem_valid, sel); end
        ack_after(5, 32'hCAFE_0005, 1);
        checks++; if (done !== 4'b0010 || err !== 4'b0) begin errors++; $display("FAIL to_ack_edge: got done=%b err=%b, required done=0010 err=0000", done, err); end
        checks++; if (resp_rdata !== 32'hCAFE_0005) begin errors++; $display("FAIL to_ack_edge_rdata: got %h, required cafe0005", resp_rdata); end
        req = 4'b0;
        tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL to_pending: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_drop_req();
        req = 4'b1000;
        tick();
        checks++; if (sel !== 2'd3) begin errors++; $display("FAIL drop_sel: got %0d, required 3", sel); end
        req = 4'b0;
        ack_after(2, 32'h0D0D_0003, 3);
        checks++; if (done !== 4'b1000) begin errors++; $display("FAIL drop_done: got %b, required 1000", done); end
        tick();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b, required 0", mem_valid); end
    endtask

    // Requester 1 completes (last = 1), requester 2 is aborted by reset.
    // Re-arbitration of 0110 must then pick 1, proving last returned to 3.
    task automatic test_reset_mid();
        req = 4'b0010;
        tick();
        ack_after(1, 32'h0000_0B01, 1);
        req = 4'b0;
        tick();
        req = 4'b0100;
        tick();
        checks++; if (mem_valid !== 1'b1 || sel !== 2'd2) begin errors++; $display("FAIL rmid_busy: got valid=%b sel=%0d, required valid=1 sel=2", mem_valid, sel); end
        #2;
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid: got %b, required 0", mem_valid); end
        tick(); tick();
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL rmid_no_done: got %b, required 0000", done); end
        mem_ready = 1'b0;
        req       = 4'b0110;
        reset_n   = 1'b1;
        tick();
        checks++; if (sel !== 2'd1 || mem_valid !== 1'b1) begin errors++; $display("FAIL rmid_regrant: got sel=%0d valid=%b, required sel=1 valid=1", sel, mem_valid); end
        ack_after(1, 32'h0000_0B02, 1);
        req = 4'b0;
        tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_pending: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_ready_idle();
        req       = 4'b0;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (done !== 4'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL idle_ready[%0d]: got done=%b valid=%b, required done=0000 valid=0", c, done, mem_valid); end
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_payload();
        test_wrap_skip();
        test_timeout();
        test_drop_req();
        test_reset_mid();
        test_ready_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
